mem_arbiter: RTL

Arbitrates a single-port, synchronous-read memory between the instruction-fetch requester and the data load/store requester of the multicycle core. Each requester issues at most one request at a time and holds it until a one-cycle `ready` pulse. On contention the arbiter alternates between the two requesters, so a back-to-back stream from one side cannot starve the other.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/rr_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the instruction/data memory arbiter.
//   - arb_state_t / ARB_*  : arbiter FSM state encoding
//   - req_id_t             : requester identity (also the owner/last_grant encoding)
package mem_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE   = 2'd0;
  localparam arb_state_t ARB_ACCESS = 2'd1;
  localparam arb_state_t ARB_RESP   = 2'd2;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the two requester handshakes and the single memory port of the
// arbiter.
//   slave  : view used by the arbiter (requests in, readies/memory strobes out)
//   master : view used by the requesters and memory model
// Signals:
//   i_req/i_addr            instruction request (read-only side)
//   d_req/d_addr/d_we/d_wdata data request
//   i_ready/i_rdata, d_ready/d_rdata   completion pulse and read data
//   mem_we/mem_addr/mem_wdata/mem_rdata single-port synchronous-read memory
//   busy/owner              arbiter status
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;

  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata,
           mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata,
           mem_we, mem_addr, mem_wdata, busy, owner
  );

endinterface

// File: rtl/rr_pick.sv
// rr_pick
// Combinational two-way round-robin selector.
// Ports:
//   i_req, d_req : pending requests
//   last_grant   : side that was served most recently
//   valid        : at least one request pending
//   id           : selected side
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_t last_grant,
  output logic    valid,
  output req_id_t id
);

  // Under contention the side that was not served last wins, so neither
  // requester can be starved by a continuous stream from the other.
  always_comb begin
    valid = i_req | d_req;
    id    = REQ_INSTR;
    if (i_req && d_req) begin
      id = (last_grant == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
    end else if (d_req) begin
      id = REQ_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port, synchronous-read memory between the instruction
// fetch and data load/store requesters. Each access takes IDLE -> ACCESS ->
// RESP, with a one-cycle ready pulse to the owner in RESP.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_arbiter_if.slave (requesters, memory port, busy/owner)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_t        state;
  req_id_t           last_grant;
  req_id_t           owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  logic              pick_valid;
  req_id_t           pick_id;
  logic              in_resp;

  rr_pick u_rr_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .id         (pick_id)
  );

  // FSM and request latches. The request is captured at grant time, so a
  // requester that drops req afterwards still gets its access completed.
  // last_grant moves only once the access is actually committed in ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= REQ_INSTR;
      owner_q    <= REQ_INSTR;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_id;
            if (pick_id == REQ_DATA) begin
              addr_q  <= bus.d_addr;
              we_q    <= bus.d_we;
              wdata_q <= bus.d_wdata;
            end else begin
              addr_q  <= bus.i_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
            state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          last_grant <= owner_q;
          state      <= ARB_RESP;
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // The write strobe is decoded from state rather than registered, so an
  // asynchronous reset during ACCESS removes it immediately.
  assign in_resp       = (state == ARB_RESP);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = (state == ARB_ACCESS) && we_q;

  // Memory read data is registered by the memory, so it lines up with RESP.
  assign bus.i_ready = in_resp && (owner_q == REQ_INSTR);
  assign bus.d_ready = in_resp && (owner_q == REQ_DATA);
  assign bus.i_rdata = bus.i_ready ? bus.mem_rdata : '0;
  assign bus.d_rdata = bus.d_ready ? bus.mem_rdata : '0;

  assign bus.busy  = (state != ARB_IDLE);
  assign bus.owner = owner_q;

endmodule
